uart_cmd_ctrl: RTL and testbench

Command sequencer between the UART receiver's parallel output and the system's register file, ALU and TX FIFO. It parses multi-byte command frames from RX bytes and issues register-file writes and reads. It also launches ALU operations and queues response bytes (read data or 16-bit ALU result) toward the UART transmitter through the TX FIFO write port.

---
 rtl/uart_sys_pkg.sv | 13 +
 rtl/cmd_timeout_cnt.sv | 20 ++
 rtl/uart_cmd_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_sys_pkg.sv
// uart_sys_pkg: opcodes, command FSM states and operand addresses shared by the UART command path.
package uart_sys_pkg;
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam int unsigned ADDR_OPA = 0;
  localparam int unsigned ADDR_OPB = 1;
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT, ST_TX_RD,
    ST_ALU_OPA, ST_ALU_OPB, ST_ALU_FUN, ST_ALU_WAIT, ST_TX_LO, ST_TX_HI
  } state_e;
endpackage

// File: rtl/cmd_timeout_cnt.sv
// cmd_timeout_cnt: loadable, clearable up-counter with a terminal-count flag.
module cmd_timeout_cnt #(
  parameter int unsigned WIDTH = 6,
  parameter logic [WIDTH-1:0] TC = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             en_i,
  output logic             tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : ld_i ? ld_val_i : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = cnt_q == TC;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses RX command frames into register-file writes/reads and ALU runs,
// and queues read data or 16-bit ALU results (low byte first) to the TX FIFO.
module uart_cmd_ctrl
  import uart_sys_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    FIFO_FULL
);
  localparam int unsigned TW = $clog2(TIMEOUT);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic [3:0] fun_q, fun_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d, cg_q, cg_d, tx_vld_q, tx_vld_d;
  logic waiting, tmo;
  assign waiting = state_q == ST_RD_WAIT || state_q == ST_ALU_WAIT;
  // cleared whenever not waiting, so each wait state starts counting from zero
  cmd_timeout_cnt #(.WIDTH(TW), .TC(TW'(TIMEOUT - 1))) u_tmo (
    .clk(CLK), .rst_n(RST_n), .clr_i(!waiting), .ld_i(1'b0), .ld_val_i('0),
    .en_i(waiting), .tc_o(tmo)
  );
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    res_d     = res_q;
    fun_d     = fun_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (RX_D_VLD)
        state_d = RX_P_DATA == CMD_RF_WR   ? ST_WR_ADDR :
                  RX_P_DATA == CMD_RF_RD   ? ST_RD_ADDR :
                  RX_P_DATA == CMD_ALU_OP  ? ST_ALU_OPA :
                  RX_P_DATA == CMD_ALU_NOP ? ST_ALU_FUN : ST_IDLE;
      ST_WR_ADDR: if (RX_D_VLD) begin
        state_d = ST_WR_DATA;
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
      end
      ST_WR_DATA: if (RX_D_VLD) begin
        state_d   = ST_IDLE;
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
      end
      ST_RD_ADDR: if (RX_D_VLD) begin
        state_d = ST_RD_WAIT;
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
      end
      ST_RD_WAIT: if (RF_RD_VLD) begin
        state_d   = ST_TX_RD;
        tx_data_d = RF_RD_DATA;
      end else if (tmo) state_d = ST_IDLE;
      ST_TX_RD: if (!FIFO_FULL) begin
        state_d  = ST_IDLE;
        tx_vld_d = 1'b1;
      end
      ST_ALU_OPA: if (RX_D_VLD) begin
        state_d   = ST_ALU_OPB;
        addr_d    = ADDR_WIDTH'(ADDR_OPA);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
      end
      ST_ALU_OPB: if (RX_D_VLD) begin
        state_d   = ST_ALU_FUN;
        addr_d    = ADDR_WIDTH'(ADDR_OPB);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
      end
      ST_ALU_FUN: if (RX_D_VLD) begin
        state_d  = ST_ALU_WAIT;
        fun_d    = RX_P_DATA[3:0];
        alu_en_d = 1'b1;
      end
      ST_ALU_WAIT: if (ALU_OUT_VLD) begin
        state_d = ST_TX_LO;
        res_d   = ALU_OUT;
      end else if (tmo) state_d = ST_IDLE;
      ST_TX_LO: if (!FIFO_FULL) begin
        state_d   = ST_TX_HI;
        tx_data_d = res_q[DATA_WIDTH-1:0];
        tx_vld_d  = 1'b1;
      end
      ST_TX_HI: if (!FIFO_FULL) begin
        state_d   = ST_IDLE;
        tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        tx_vld_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    cg_d = state_d == ST_ALU_FUN || state_d == ST_ALU_WAIT;
  end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      res_q     <= '0;
      fun_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      cg_q      <= 1'b0;
      tx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      res_q     <= res_d;
      fun_q     <= fun_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      cg_q      <= cg_d;
      tx_vld_q  <= tx_vld_d;
    end
  assign RF_ADDR     = addr_q;
  assign RF_WR_EN    = wr_en_q;
  assign RF_RD_EN    = rd_en_q;
  assign RF_WR_DATA  = wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = fun_q;
  assign CLK_GATE_EN = cg_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed command frames; expected strobes are queued and checked by a monitor.
module tb_uart_cmd_ctrl;
  import uart_sys_pkg::*;
  localparam int TIMEOUT = 64;
  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ALU = 2'd2, K_TX = 2'd3;
  typedef struct packed {logic [1:0] kind; logic [3:0] af; logic [7:0] data;} ev_t;
  logic CLK = 1'b0, RST_n = 1'b0;
  logic [7:0] RX_P_DATA = '0, RF_WR_DATA, RF_RD_DATA = '0, TX_P_DATA;
  logic RX_D_VLD = 1'b0, RF_WR_EN, RF_RD_EN, RF_RD_VLD = 1'b0, ALU_EN, ALU_OUT_VLD = 1'b0;
  logic CLK_GATE_EN, TX_D_VLD, FIFO_FULL = 1'b0, prev_cg = 1'b0;
  logic [3:0] RF_ADDR, ALU_FUN;
  logic [15:0] ALU_OUT = '0;
  logic [28:0] outs;
  ev_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  uart_cmd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_n(RST_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
  );
  always #5 CLK = ~CLK;
  assign outs = {RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD};
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic pop_chk(input string nm, input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected event 0x%0h, expected none (t=%0t)", nm, got, $time);
    end else begin
      e = exp_q.pop_front();
      chk(nm, int'(got), int'(e));
    end
  endtask
  task automatic push(input logic [1:0] k, input logic [3:0] af, input logic [7:0] d);
    exp_q.push_back('{kind: k, af: af, data: d});
  endtask
  always @(negedge CLK) prev_cg <= CLK_GATE_EN;
  always @(negedge CLK) if (RST_n) begin
    if (RF_WR_EN) pop_chk("rf_write", '{kind: K_WR, af: RF_ADDR, data: RF_WR_DATA});
    if (RF_RD_EN) pop_chk("rf_read", '{kind: K_RD, af: RF_ADDR, data: 8'h00});
    if (ALU_EN) begin
      pop_chk("alu_start", '{kind: K_ALU, af: ALU_FUN, data: 8'h00});
      chk("clk_gate_early", int'({prev_cg, CLK_GATE_EN}), 3);
    end
    if (TX_D_VLD) begin
      pop_chk("tx_byte", '{kind: K_TX, af: 4'h0, data: TX_P_DATA});
      chk("tx_not_while_full", int'(FIFO_FULL), 0);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    cyc(1);
    RX_D_VLD  = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    cyc(2);
    chk("reset_outputs", int'(outs), 0);
    chk("reset_state", int'(dut.state_q), int'(ST_IDLE));
    RST_n = 1'b1;
    cyc(2);
    // write, then a read opcode in the very next cycle
    push(K_WR, 4'h5, 8'h3C);
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_timing", int'({RF_WR_EN, RF_ADDR, RF_WR_DATA}), int'({1'b1, 4'h5, 8'h3C}));
    push(K_RD, 4'h7, 8'h00);
    push(K_TX, 4'h0, 8'h5A);
    send(8'hBB); send(8'h07);
    chk("rd_en_timing", int'(RF_RD_EN), 1);
    cyc(2);
    RF_RD_DATA = 8'h5A; RF_RD_VLD = 1'b1;
    cyc(1);
    RF_RD_VLD = 1'b0;
    chk("rd_lat_n1", int'(TX_D_VLD), 0);
    cyc(1);
    chk("rd_lat_n2", int'({TX_D_VLD, TX_P_DATA}), int'({1'b1, 8'h5A}));
    cyc(2);
    // ALU with operands
    push(K_WR, 4'h0, 8'h12);
    push(K_WR, 4'h1, 8'h34);
    push(K_ALU, 4'h2, 8'h00);
    push(K_TX, 4'h0, 8'h68);
    push(K_TX, 4'h0, 8'h04);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
    chk("alu_en_timing", int'({ALU_EN, ALU_FUN}), int'({1'b1, 4'h2}));
    cyc(2);
    ALU_OUT = 16'h0468; ALU_OUT_VLD = 1'b1;
    cyc(1);
    ALU_OUT_VLD = 1'b0;
    chk("alu_lat_n1", int'(TX_D_VLD), 0);
    cyc(1);
    chk("alu_lo_n2", int'({TX_D_VLD, TX_P_DATA}), int'({1'b1, 8'h68}));
    cyc(1);
    chk("alu_hi_n3", int'({TX_D_VLD, TX_P_DATA}), int'({1'b1, 8'h04}));
    cyc(1);
    chk("cg_off_after_alu", int'(CLK_GATE_EN), 0);
    // ALU without operands, FIFO full around the result
    push(K_ALU, 4'h1, 8'h00);
    push(K_TX, 4'h0, 8'hCD);
    push(K_TX, 4'h0, 8'hAB);
    send(8'hDD);
    chk("cg_in_alu_fun", int'(CLK_GATE_EN), 1);
    send(8'h01);
    FIFO_FULL = 1'b1;
    cyc(2);
    ALU_OUT = 16'hABCD; ALU_OUT_VLD = 1'b1;
    cyc(1);
    ALU_OUT_VLD = 1'b0;
    cyc(7);
    chk("held_while_full", int'({TX_D_VLD, dut.state_q}), int'({1'b0, ST_TX_LO}));
    FIFO_FULL = 1'b0;
    chk("full_release_n0", int'(TX_D_VLD), 0);
    cyc(1);
    chk("full_lo", int'({TX_D_VLD, TX_P_DATA}), int'({1'b1, 8'hCD}));
    cyc(1);
    chk("full_hi", int'({TX_D_VLD, TX_P_DATA}), int'({1'b1, 8'hAB}));
    cyc(1);
    chk("full_done_idle", int'(dut.state_q), int'(ST_IDLE));
    // read timeout with no valid
    push(K_RD, 4'h3, 8'h00);
    send(8'hBB); send(8'h03);
    n = 0;
    while (dut.state_q == ST_RD_WAIT && n < 200) begin
      n++;
      cyc(1);
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_idle", int'(dut.state_q), int'(ST_IDLE));
    push(K_WR, 4'h1, 8'hFF);
    send(8'hAA); send(8'h01); send(8'hFF);
    cyc(2);
    // valid in the same cycle the timeout fires wins
    push(K_RD, 4'h2, 8'h00);
    push(K_TX, 4'h0, 8'h77);
    send(8'hBB); send(8'h02);
    cyc(TIMEOUT - 1);
    RF_RD_DATA = 8'h77; RF_RD_VLD = 1'b1;
    cyc(1);
    RF_RD_VLD = 1'b0;
    chk("vld_at_tc_state", int'(dut.state_q), int'(ST_TX_RD));
    cyc(1);
    chk("vld_at_tc_tx", int'({TX_D_VLD, TX_P_DATA}), int'({1'b1, 8'h77}));
    cyc(2);
    // unknown opcode, then reset in the middle of CC 12
    send(8'h55);
    chk("unknown_opcode_idle", int'(dut.state_q), int'(ST_IDLE));
    send(8'hCC);
    chk("cc_entered_opa", int'(dut.state_q), int'(ST_ALU_OPA));
    RST_n = 1'b0;
    #1;
    chk("midreset_outputs", int'(outs), 0);
    chk("midreset_state", int'(dut.state_q), int'(ST_IDLE));
    cyc(1);
    RST_n = 1'b1;
    send(8'h12);
    cyc(3);
    chk("post_reset_outputs", int'(outs), 0);
    chk("post_reset_state", int'(dut.state_q), int'(ST_IDLE));
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
